// File: rtl/fetch_4t_pkg.sv
// fetch_4t_pkg: shared types, thread count and reset-PC layout for the 4-thread fetch front end
package fetch_4t_pkg;
    localparam int          NUM_THREADS     = 4;
    localparam logic [31:0] RESET_PC_BASE   = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_STRIDE = 32'h0000_0400;
    typedef logic [1:0] t_thread_id;
    function automatic logic [31:0] reset_pc(input t_thread_id t);
        return RESET_PC_BASE + RESET_PC_STRIDE * {30'b0, t};
    endfunction
endpackage

// File: rtl/fetch_4t_if.sv
// fetch_4t_if: fetch front-end bus (control in, Q100H i_mem request, Q101H decode feed)
//   master: core side (drives enables, stall, redirect, returned instruction)
//   slave : fetch unit (drives Q100H request and Q101H instruction/tag)
interface fetch_4t_if;
    import fetch_4t_pkg::*;
    logic [3:0]  ThreadEnQnnnH;
    logic        StallQ100H;
    logic        RedirectValidQ102H;
    t_thread_id  RedirectThreadQ102H;
    logic [31:0] RedirectPcQ102H;
    logic [31:0] PcQ100H;
    logic        RdEnableQ100H;
    t_thread_id  ThreadQ100H;
    logic [31:0] InstFetchQ101H;
    logic [31:0] InstQ101H;
    logic        InstValidQ101H;
    t_thread_id  ThreadQ101H;
    logic [31:0] PcQ101H;
    modport master (
        output ThreadEnQnnnH, StallQ100H, RedirectValidQ102H, RedirectThreadQ102H, RedirectPcQ102H, InstFetchQ101H,
        input  PcQ100H, RdEnableQ100H, ThreadQ100H, InstQ101H, InstValidQ101H, ThreadQ101H, PcQ101H
    );
    modport slave (
        input  ThreadEnQnnnH, StallQ100H, RedirectValidQ102H, RedirectThreadQ102H, RedirectPcQ102H, InstFetchQ101H,
        output PcQ100H, RdEnableQ100H, ThreadQ100H, InstQ101H, InstValidQ101H, ThreadQ101H, PcQ101H
    );
endinterface

// File: rtl/fetch_4t_pc_bank.sv
// fetch_4t_pc_bank: per-thread PC registers with redirect-over-increment priority
//   QClk/RstQnnnH : clock, sync active-high reset
//   i_fetch       : the selected thread is being fetched this cycle
//   i_thread      : thread in the Q100H slot (read and increment target)
//   i_redir_*     : redirect valid/thread/target (target already word-aligned)
//   o_pc          : PC of i_thread
module fetch_4t_pc_bank
    import fetch_4t_pkg::*;
(
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic        i_fetch,
    input  t_thread_id  i_thread,
    input  logic        i_redir_valid,
    input  t_thread_id  i_redir_thread,
    input  logic [31:0] i_redir_pc,
    output logic [31:0] o_pc
);
    logic [31:0] r_pc [NUM_THREADS];

    always_ff @(posedge QClk) begin
        for (int n = 0; n < NUM_THREADS; n++) begin
            if (RstQnnnH)
                r_pc[n] <= reset_pc(t_thread_id'(n));
            else if (i_redir_valid && i_redir_thread == t_thread_id'(n))
                r_pc[n] <= i_redir_pc;
            else if (i_fetch && i_thread == t_thread_id'(n))
                r_pc[n] <= r_pc[n] + 32'd4;
        end
    end

    assign o_pc = r_pc[i_thread];
endmodule

// File: rtl/fetch_4t.sv
// fetch_4t: barrel-thread instruction fetch, round-robin over 4 threads, 1-cycle Q101H tag pipe
//   QClk     : core clock
//   RstQnnnH : sync active-high reset
//   bus      : fetch_4t_if.slave (enables, stall, redirect, i_mem request/response, decode feed)
module fetch_4t
    import fetch_4t_pkg::*;
(
    input  logic        QClk,
    input  logic        RstQnnnH,
    fetch_4t_if.slave   bus
);
    t_thread_id  r_thread;
    t_thread_id  r_thread_q101;
    logic        r_valid_q101;
    logic [31:0] r_pc_q101;
    logic [31:0] w_pc;
    logic        w_kill;
    logic        w_rd_en;

    // a redirect landing on the thread currently in slot suppresses its stale fetch
    assign w_kill  = bus.RedirectValidQ102H && bus.RedirectThreadQ102H == r_thread;
    assign w_rd_en = bus.ThreadEnQnnnH[r_thread] & ~bus.StallQ100H & ~RstQnnnH & ~w_kill;

    fetch_4t_pc_bank u_pc_bank (
        .QClk           (QClk),
        .RstQnnnH       (RstQnnnH),
        .i_fetch        (w_rd_en),
        .i_thread       (r_thread),
        .i_redir_valid  (bus.RedirectValidQ102H),
        .i_redir_thread (bus.RedirectThreadQ102H),
        .i_redir_pc     (bus.RedirectPcQ102H & 32'hFFFF_FFFC),
        .o_pc           (w_pc)
    );

    // disabled threads keep their slot, so the pointer advances on every unstalled cycle
    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            r_thread      <= '0;
            r_valid_q101  <= 1'b0;
            r_thread_q101 <= '0;
            r_pc_q101     <= '0;
        end else begin
            if (!bus.StallQ100H)
                r_thread <= r_thread + 2'd1;
            r_valid_q101 <= w_rd_en;
            if (w_rd_en) begin
                r_thread_q101 <= r_thread;
                r_pc_q101     <= w_pc;
            end
        end
    end

    assign bus.PcQ100H        = w_pc;
    assign bus.RdEnableQ100H  = w_rd_en;
    assign bus.ThreadQ100H    = r_thread;
    assign bus.InstQ101H      = r_valid_q101 ? bus.InstFetchQ101H : 32'h0;
    assign bus.InstValidQ101H = r_valid_q101;
    assign bus.ThreadQ101H    = r_thread_q101;
    assign bus.PcQ101H        = r_pc_q101;
endmodule
